alu_exec_stage: RTL and testbench

Execute/write-back stage that sits directly downstream of the 4×32-bit register file and closes the loop back into its write port. It accepts one register-to-register instruction at a time over a valid/ready handshake and drives the file's two read-address ports. It captures the operands, computes an ALU or iterative multiply result, and writes it back through the file's write port. The file gates its write clock with `regWrite`, so this block times its write-port outputs to keep that gated clock glitch-free.

---
 rtl/alu_exec_pkg.sv | 29 ++
 rtl/alu_exec_stage_mul.sv | 48 ++++
 rtl/alu_exec_stage.sv | 158 +++++++++++++++
 tb/tb_alu_exec_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types and defaults for the execute/write-back stage.
package alu_exec_pkg;

  localparam int unsigned W_DEFAULT          = 32;
  localparam int unsigned MUL_CYCLES_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SLT  = 3'b100,
    OP_MUL  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_e;

  function automatic logic op_reserved(input op_e op);
    return (op == OP_RSV6) || (op == OP_RSV7);
  endfunction

endpackage

// File: rtl/alu_exec_stage_mul.sv
// Iterative unsigned shift-add multiplier, low W bits of the product.
module mul_shift_add
  import alu_exec_pkg::*;
#(
  parameter int unsigned W          = W_DEFAULT,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic [W-1:0] product
);

  localparam int unsigned CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  mcand_q;
  logic [W-1:0]  mplier_q;

  // The load edge also accumulates partial product 0, so the remaining
  // MUL_CYCLES-1 iterations run while the counter is non-zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      acc_q    <= b[0] ? a : '0;
      mcand_q  <= a << 1;
      mplier_q <= b >> 1;
      cnt_q    <= CW'(MUL_CYCLES - 1);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  assign busy    = (cnt_q != '0);
  assign product = acc_q;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/write-back stage: reads two registers, runs ALU or multiply,
// writes the result back through a negedge-timed register-file write port.
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int unsigned W          = W_DEFAULT,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inst_valid,
  output logic         inst_ready,
  input  logic [2:0]   inst_op,
  input  logic [1:0]   inst_rs,
  input  logic [1:0]   inst_rt,
  input  logic [1:0]   inst_rd,
  output logic [1:0]   readReg1,
  output logic [1:0]   readReg2,
  input  logic [W-1:0] readData1,
  input  logic [W-1:0] readData2,
  output logic [1:0]   writeRegNo,
  output logic [W-1:0] writeData,
  output logic         regWrite,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result
);

  state_e       state_q, state_d;
  op_e          op_q;
  logic [1:0]   rd_q;
  logic [W-1:0] a_q, b_q, res_q, alu_y;
  logic         mul_started_q;
  logic         accept, mul_start, load_res, fin_ok, fin_err;
  logic         mul_busy;
  logic [W-1:0] mul_prod;

  mul_shift_add #(
    .W          (W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (a_q),
    .b       (b_q),
    .busy    (mul_busy),
    .product (mul_prod)
  );

  assign inst_ready = (state_q == S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    mul_start = 1'b0;
    load_res  = 1'b0;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inst_valid) begin
          accept  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        if (op_reserved(op_q)) begin
          fin_err = 1'b1;
          state_d = S_IDLE;
        end else if (op_q == OP_MUL) begin
          if (!mul_started_q) begin
            mul_start = 1'b1;
          end else if (!mul_busy) begin
            load_res = 1'b1;
            state_d  = S_WRITE;
          end
        end else begin
          load_res = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        fin_ok  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (op_q)
      OP_ADD:  alu_y = a_q + b_q;
      OP_SUB:  alu_y = a_q - b_q;
      OP_AND:  alu_y = a_q & b_q;
      OP_OR:   alu_y = a_q | b_q;
      OP_SLT:  alu_y = {{(W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q          <= OP_ADD;
      rd_q          <= '0;
      readReg1      <= '0;
      readReg2      <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      result        <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      mul_started_q <= 1'b0;
    end else begin
      done <= fin_ok | fin_err;
      err  <= fin_err;
      if (accept) begin
        op_q     <= op_e'(inst_op);
        rd_q     <= inst_rd;
        readReg1 <= inst_rs;
        readReg2 <= inst_rt;
      end
      if (state_q == S_READ) begin
        a_q <= readData1;
        b_q <= readData2;
      end
      if (mul_start)              mul_started_q <= 1'b1;
      else if (state_q != S_EXEC) mul_started_q <= 1'b0;
      if (load_res) res_q <= (op_q == OP_MUL) ? mul_prod : alu_y;
      if (fin_ok)   result <= res_q;
    end
  end

  // Both regWrite transitions happen while clock is low, so the file's
  // gated write clock sees exactly the posedge that ends WRITE.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      regWrite   <= 1'b0;
      writeRegNo <= '0;
      writeData  <= '0;
    end else begin
      regWrite <= (state_q == S_WRITE);
      if (state_q == S_WRITE) begin
        writeRegNo <= rd_q;
        writeData  <= res_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench: 4x32 register file model with gated write clock,
// directed cases followed by randomized instructions.
module tb_alu_exec_stage;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         inst_valid = 1'b0;
  logic         inst_ready;
  logic [2:0]   inst_op = '0;
  logic [1:0]   inst_rs = '0, inst_rt = '0, inst_rd = '0;
  logic [1:0]   readReg1, readReg2, writeRegNo;
  logic [W-1:0] readData1, readData2, writeData, result;
  logic         regWrite, done, err;

  always #5 clock = ~clock;

  alu_exec_stage #(.W(32), .MUL_CYCLES(32)) dut (
    .clock(clock), .reset(reset),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_op(inst_op),
    .inst_rs(inst_rs), .inst_rt(inst_rt), .inst_rd(inst_rd),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2),
    .writeRegNo(writeRegNo), .writeData(writeData), .regWrite(regWrite),
    .done(done), .err(err), .result(result)
  );

  // Register file: writes land on rising edges of the gated write clock.
  logic [W-1:0] rf [4];
  logic         pre_we = 1'b0;
  logic [1:0]   pre_addr = '0;
  logic [W-1:0] pre_data = '0;
  logic         wclk;
  int           gedges = 0;

  assign wclk      = clock & (regWrite | pre_we);
  assign readData1 = rf[readReg1];
  assign readData2 = rf[readReg2];

  always @(posedge wclk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else begin
      rf[writeRegNo] <= writeData;
      gedges <= gedges + 1;
    end
  end

  typedef struct {
    logic            err;
    logic [31:0]     val;
    int              lat;
    int              acc;
    int              gexp;
    logic [3:0][31:0] snap;
  } exp_t;

  exp_t             q[$];
  logic [3:0][31:0] ref_rf = '0;
  int               exp_gedges = 0;
  int               cyc = 0;
  int               total = 0;
  int               bad = 0;
  int               infl_start = 0;
  int               infl_end = 0;
  int               ready_viol = 0;
  int               glitch = 0;
  bit               armed = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock)
    if (cyc >= infl_start && cyc < infl_end && inst_ready) ready_viol <= ready_viol + 1;

  always @(regWrite)
    if (armed && clock) glitch <= glitch + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour written directly from the opcode table.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (armed && done) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 want no completion (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("latency", cyc - e.acc, e.lat);
          if (!e.err) chk("result", result, e.val);
          chk("gated_edges", gedges, e.gexp);
          for (int r = 0; r < 4; r++) chk($sformatf("rf%0d", r), rf[r], e.snap[r]);
          chk("ready_low_busy", ready_viol, 0);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rt,
                       input logic [1:0] rd, input bit push);
    int   n;
    bit   ok;
    exp_t e;
    n  = 0;
    ok = 1'b0;
    @(negedge clock);
    inst_valid = 1'b1; inst_op = op; inst_rs = rs; inst_rt = rt; inst_rd = rd;
    while (!ok && n < 200) begin
      if (inst_ready) ok = 1'b1;
      else begin @(negedge clock); n++; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: got inst_ready=0 want 1 within 200 cycles");
      inst_valid = 1'b0;
    end else begin
      e.acc = cyc + 1;
      e.err = (op == 3'd6) || (op == 3'd7);
      e.lat = e.err ? 2 : ((op == 3'd5) ? 35 : 3);
      e.val = model(op, ref_rf[rs], ref_rf[rt]);
      infl_start = e.acc;
      infl_end   = e.acc + e.lat;
      if (push) begin
        if (!e.err) begin
          ref_rf[rd] = e.val;
          exp_gedges++;
        end
        e.gexp = exp_gedges;
        e.snap = ref_rf;
        q.push_back(e);
      end
      @(posedge clock);
      #1 inst_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (!(q.size() == 0 && inst_ready) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL idle_timeout: got pending=%0d want 0", q.size());
    end
  endtask

  task automatic preload(input logic [1:0] addr, input logic [31:0] data);
    wait_idle();
    pre_addr = addr; pre_data = data; pre_we = 1'b1;
    ref_rf[addr] = data;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [2:0]  op;
    logic [31:0] v;
    repeat (3) @(negedge clock);
    chk("rst_inst_ready", {31'd0, inst_ready}, 32'd1);
    chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_readReg", {28'd0, readReg1, readReg2}, 32'd0);
    chk("rst_writeRegNo", {30'd0, writeRegNo}, 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b1;
    armed = 1'b1;

    preload(2'd0, 32'd0);
    preload(2'd1, 32'd5);
    preload(2'd2, 32'd7);
    preload(2'd3, 32'd0);
    issue(3'd0, 2'd1, 2'd2, 2'd3, 1'b1);   // ADD -> 12
    wait_idle();
    issue(3'd1, 2'd1, 2'd2, 2'd0, 1'b1);   // SUB -> fffffffe
    issue(3'd4, 2'd1, 2'd2, 2'd3, 1'b1);   // SLT -> 1
    issue(3'd0, 2'd1, 2'd2, 2'd3, 1'b1);   // dependent pair -> r0=24
    issue(3'd0, 2'd3, 2'd3, 2'd0, 1'b1);
    preload(2'd1, 32'h8000_0000);
    preload(2'd2, 32'd1);
    issue(3'd4, 2'd1, 2'd2, 2'd3, 1'b1);   // signed SLT -> 1
    preload(2'd1, 32'h0001_0003);
    preload(2'd2, 32'h0002_0000);
    issue(3'd5, 2'd1, 2'd2, 2'd3, 1'b1);   // MUL -> 00060000
    issue(3'd6, 2'd1, 2'd2, 2'd0, 1'b1);   // reserved
    issue(3'd7, 2'd2, 2'd1, 2'd1, 1'b1);
    wait_idle();

    issue(3'd5, 2'd1, 2'd2, 2'd0, 1'b0);   // MUL aborted by reset
    repeat (10) @(posedge clock);
    #2;
    infl_end = 0;
    reset = 1'b0;
    #1;
    chk("abort_inst_ready", {31'd0, inst_ready}, 32'd1);
    chk("abort_regWrite", {31'd0, regWrite}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_readReg1", {30'd0, readReg1}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    issue(3'd0, 2'd1, 2'd2, 2'd3, 1'b1);   // -> 00030003
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: v = 32'h8000_0000;
          1: v = 32'hFFFF_FFFF;
          default: v = $urandom;
        endcase
        preload(2'($urandom_range(0, 3)), v);
      end
      op = 3'($urandom_range(0, 7));
      if (op == 3'd5 && $urandom_range(0, 2) != 0) op = 3'($urandom_range(0, 4));
      issue(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
    end

    wait_idle();
    chk("scoreboard_drained", q.size(), 0);
    chk("regWrite_while_clock_high", glitch, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
